// File: rtl/accumulator_pkg.sv
// Shared types, default widths and the saturating counter helper for the stream accumulator.
package accumulator_pkg;

  typedef enum logic {ACC, DONE} acc_state_t;

  localparam int N_DEF  = 8;
  localparam int CW_DEF = 8;

  function automatic int unsigned sat_inc(input int unsigned count, input int unsigned max_val);
    return (count >= max_val) ? count : count + 32'd1;
  endfunction

endpackage

// File: rtl/accumulator_if.sv
// Beat input and frame-result output handshakes of the accumulator; master drives beats and consumes results.
interface accumulator_if #(
  parameter int N  = 8,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_sum;
  logic          out_carry;
  logic [CW-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_count
  );
endinterface

// File: rtl/accumulator_adder.sv
// Catalog n-bit ripple adder: purely combinational sum and carry-out.
// Latency 0; no flow control.
module accumulator_adder #(
  parameter int n = 8
) (
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  input  logic         cin_i,
  output logic [n-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = (n+1)'(a_i) + (n+1)'(b_i) + (n+1)'(cin_i);

endmodule

// File: rtl/accumulator.sv
// Stream accumulator: sums beats of a frame, presents total/sticky carry/beat count; latency 1 after last beat.
// A held result stalls input until taken; taking it and accepting the next beat may share a cycle.
module accumulator
  import accumulator_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  accumulator_if.slave bus
);

  localparam int unsigned CNT_MAX = (32'd1 << CW) - 32'd1;

  acc_state_t    state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  out_sum_q, out_sum_d;
  logic          out_carry_q, out_carry_d;
  logic [CW-1:0] out_count_q, out_count_d;

  logic [N-1:0]  sum;
  logic          cout;
  logic          out_valid;
  logic          out_fire;
  logic          in_ready;
  logic          in_fire;
  logic          carry_next;
  logic [CW-1:0] count_next;

  assign out_valid  = (state_q == DONE);
  assign out_fire   = out_valid & bus.out_ready;
  assign in_ready   = ~clr & ((state_q == ACC) | out_fire);
  assign in_fire    = bus.in_valid & in_ready;
  assign carry_next = carry_q | cout;
  assign count_next = CW'(sat_inc(32'(count_q), CNT_MAX));

  // acc/carry/count are zeroed whenever a frame closes, so in DONE the adder already sees 0 + in_data.
  accumulator_adder #(.n(N)) u_adder (
    .a_i    (acc_q),
    .b_i    (bus.in_data),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (cout)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    count_d     = count_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    out_count_d = out_count_q;

    if (clr) begin
      state_d = ACC;
      acc_d   = '0;
      carry_d = 1'b0;
      count_d = '0;
    end else begin
      if (out_fire) begin
        state_d = ACC;
        acc_d   = '0;
        carry_d = 1'b0;
        count_d = '0;
      end
      if (in_fire) begin
        acc_d   = sum;
        carry_d = carry_next;
        count_d = count_next;
        if (bus.in_last) begin
          out_sum_d   = sum;
          out_carry_d = carry_next;
          out_count_d = count_next;
          acc_d       = '0;
          carry_d     = 1'b0;
          count_d     = '0;
          state_d     = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_carry = out_carry_q;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_accumulator.sv
// Bench for accumulator: two instances (CW=8 and CW=2) share stimulus and are checked against a frame-level model.
module tb_accumulator;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;

  int total = 0;
  int bad   = 0;

  accumulator_if #(.N(8), .CW(8)) ia ();
  accumulator_if #(.N(8), .CW(2)) ib ();

  assign ia.in_valid  = in_valid;
  assign ia.in_data   = in_data;
  assign ia.in_last   = in_last;
  assign ia.out_ready = out_ready;
  assign ib.in_valid  = in_valid;
  assign ib.in_data   = in_data;
  assign ib.in_last   = in_last;
  assign ib.out_ready = out_ready;

  accumulator #(.N(8), .CW(8)) dut_a (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(ia.slave));
  accumulator #(.N(8), .CW(2)) dut_b (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(ib.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: running frame totals plus the one held result.
  int m_sum, m_cnt, h_sum, h_cnt;
  bit m_carry, h_carry, hv;

  always @(negedge clk) begin
    bit exp_rdy, fire_in, fire_out;
    if (!rst_n) begin
      m_sum = 0; m_cnt = 0; m_carry = 0;
      h_sum = 0; h_cnt = 0; h_carry = 0; hv = 0;
    end else begin
      exp_rdy = !clr && (!hv || out_ready);
      check("in_ready_a", 32'(ia.in_ready), 32'(exp_rdy));
      check("in_ready_b", 32'(ib.in_ready), 32'(exp_rdy));
      check("out_valid_a", 32'(ia.out_valid), 32'(hv));
      check("out_valid_b", 32'(ib.out_valid), 32'(hv));
      if (hv) begin
        check("out_sum_a", 32'(ia.out_sum), 32'(h_sum));
        check("out_sum_b", 32'(ib.out_sum), 32'(h_sum));
        check("out_carry_a", 32'(ia.out_carry), 32'(h_carry));
        check("out_carry_b", 32'(ib.out_carry), 32'(h_carry));
        check("out_count_a", 32'(ia.out_count), 32'((h_cnt > 255) ? 255 : h_cnt));
        check("out_count_b", 32'(ib.out_count), 32'((h_cnt > 3) ? 3 : h_cnt));
      end
      fire_in  = in_valid && exp_rdy;
      fire_out = hv && out_ready;
      if (clr) begin
        m_sum = 0; m_cnt = 0; m_carry = 0; hv = 0;
      end else begin
        if (fire_out) hv = 0;
        if (fire_in) begin
          m_sum = m_sum + int'(in_data);
          if (m_sum > 255) begin
            m_sum   = m_sum - 256;
            m_carry = 1;
          end
          m_cnt++;
          if (in_last) begin
            hv = 1; h_sum = m_sum; h_carry = m_carry; h_cnt = m_cnt;
            m_sum = 0; m_cnt = 0; m_carry = 0;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ia.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic expect_result(input string name, input int s, input int c, input int ca, input int cb);
    @(negedge clk);
    check({name, "_valid"}, 32'(ia.out_valid), 32'd1);
    check({name, "_sum"}, 32'(ia.out_sum), 32'(s));
    check({name, "_carry"}, 32'(ia.out_carry), 32'(c));
    check({name, "_count_a"}, 32'(ia.out_count), 32'(ca));
    check({name, "_count_b"}, 32'(ib.out_count), 32'(cb));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(ia.out_valid), 32'd0);
    check("rst_out_sum", 32'(ia.out_sum), 32'd0);
    check("rst_out_count", 32'(ia.out_count), 32'd0);
    check("rst_in_ready", 32'(ia.in_ready), 32'd1);
    @(posedge clk); #1;

    send(8'd3, 1'b0); send(8'd4, 1'b0); send(8'd5, 1'b1);
    expect_result("frame345", 12, 0, 3, 3);
    idle(2);

    send(8'd200, 1'b0); send(8'd100, 1'b1);
    expect_result("overflow", 44, 1, 2, 2);
    idle(2);

    out_ready = 1'b0;
    send(8'd1, 1'b0); send(8'd2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_sum", 32'(ia.out_sum), 32'd3);
      check("bp_in_ready", 32'(ia.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'd9; in_last = 1'b1;
    @(negedge clk);
    check("handoff_in_ready", 32'(ia.in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    expect_result("handoff", 9, 0, 1, 1);
    idle(2);

    send(8'd10, 1'b0); send(8'd20, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("abort_no_result", 32'(ia.out_valid), 32'd0);
    @(posedge clk); #1;
    send(8'd7, 1'b1);
    expect_result("abort", 7, 0, 1, 1);
    idle(2);

    for (int i = 0; i < 5; i++) send(8'd1, (i == 4) ? 1'b1 : 1'b0);
    expect_result("saturate", 5, 0, 5, 3);
    idle(2);

    out_ready = 1'b0;
    send(8'd250, 1'b0); send(8'd10, 1'b1);
    expect_result("pre_reset", 4, 1, 2, 2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(ia.out_valid), 32'd0);
    check("async_rst_sum", 32'(ia.out_sum), 32'd0);
    check("async_rst_carry", 32'(ia.out_carry), 32'd0);
    check("async_rst_count", 32'(ia.out_count), 32'd0);
    check("async_rst_count_b", 32'(ib.out_count), 32'd0);
    idle(2);
    rst_n = 1'b1; out_ready = 1'b1;
    idle(1);

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      clr       = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; clr = 1'b0; out_ready = 1'b1;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
